// File: rtl/sort_chunk_feeder.sv
// Packs a serial record stream into 2^P_LOG-lane chunks for the merge sorting network,
// pads short final chunks with PAD_KEY, and issues chunks under credit control.
// Optional statistics outputs STAT_CHUNKS/STAT_PADS are enabled by defining SORT_FEEDER_STAT_EN.
module sort_chunk_feeder #(
  parameter int P_LOG = 4,
  parameter int DATW = 64,
  parameter int KEYW = 32,
  parameter int CREDITS = 4,
  parameter logic [KEYW-1:0] PAD_KEY = {KEYW{1'b1}},
  localparam int N = 1 << P_LOG,
  localparam int CW = $clog2(CREDITS + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATW-1:0]   DIN,
  input  logic              DIN_VALID,
  input  logic              DIN_LAST,
  output logic              DIN_READY,
  output logic [DATW*N-1:0] NET_DIN,
  output logic              NET_DINEN,
  output logic              CHUNK_LAST,
  input  logic              CRD_RET,
  output logic [CW-1:0]     CREDIT_CNT,
  output logic              BUSY,
  output logic              CRD_ERR
`ifdef SORT_FEEDER_STAT_EN
  ,
  output logic [31:0]       STAT_CHUNKS,
  output logic [31:0]       STAT_PADS
`endif
);

  typedef enum logic [1:0] {FILL, PAD, ISSUE} state_t;

  localparam logic [P_LOG-1:0] LAST_LANE = P_LOG'(N - 1);
  localparam logic [CW-1:0]    CRED_MAX  = CW'(CREDITS);
  localparam logic [DATW-1:0]  PAD_REC   = DATW'(PAD_KEY);

  state_t           state;
  logic [P_LOG-1:0] idx;
  logic             last_flag;
  logic             xfer;
  logic             issue;

  assign DIN_READY  = (state == FILL);
  assign xfer       = DIN_VALID & DIN_READY;
  // The issue pulse is taken straight from registered state so a chunk goes out
  // in the very cycle ISSUE is entered whenever a credit is available.
  assign issue      = (state == ISSUE) && (CREDIT_CNT != '0);
  assign NET_DINEN  = issue;
  assign CHUNK_LAST = issue & last_flag;
  assign BUSY       = (state != FILL) || (idx != '0);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FILL;
      idx       <= '0;
      last_flag <= 1'b0;
      // NOTE: the lane register is reset deliberately; NET_DIN must read zero after reset.
      NET_DIN   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (xfer) begin
            NET_DIN[DATW*int'(idx) +: DATW] <= DIN;
            idx <= idx + 1'b1;
            if (idx == LAST_LANE) begin
              state     <= ISSUE;
              last_flag <= DIN_LAST;
            end else if (DIN_LAST) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          for (int i = 0; i < N; i++) begin
            if (i >= int'(idx)) NET_DIN[DATW*i +: DATW] <= PAD_REC;
          end
          last_flag <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: begin
          if (issue) begin
            idx   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // A return that would push the count past CREDITS is dropped and flagged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CREDIT_CNT <= CRED_MAX;
      CRD_ERR    <= 1'b0;
    end else begin
      case ({issue, CRD_RET})
        2'b10: CREDIT_CNT <= CREDIT_CNT - 1'b1;
        2'b01: begin
          if (CREDIT_CNT == CRED_MAX) CRD_ERR <= 1'b1;
          else CREDIT_CNT <= CREDIT_CNT + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_FEEDER_STAT_EN
  localparam logic [P_LOG:0] N_LANES = (P_LOG + 1)'(N);
  logic [P_LOG:0] pad_lanes;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pad_lanes   <= '0;
      STAT_CHUNKS <= '0;
      STAT_PADS   <= '0;
    end else begin
      if (state == PAD) pad_lanes <= N_LANES - {1'b0, idx};
      else if (xfer && idx == LAST_LANE) pad_lanes <= '0;
      if (issue) begin
        STAT_CHUNKS <= STAT_CHUNKS + 32'd1;
        STAT_PADS   <= STAT_PADS + 32'(pad_lanes);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sort_chunk_feeder.sv
// Self-checking bench for sort_chunk_feeder: directed scenarios followed by random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_sort_chunk_feeder;
  localparam int P_LOG = 4;
  localparam int N = 16;
  localparam int DATW = 64;
  localparam int CREDITS = 4;
  localparam int CW = 3;
  localparam int W = DATW * N;
  localparam logic [DATW-1:0] PAD_REC = 64'h0000_0000_FFFF_FFFF;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DATW-1:0] DIN = '0;
  logic            DIN_VALID = 1'b0;
  logic            DIN_LAST = 1'b0;
  logic            DIN_READY;
  logic [W-1:0]    NET_DIN;
  logic            NET_DINEN;
  logic            CHUNK_LAST;
  logic            CRD_RET = 1'b0;
  logic [CW-1:0]   CREDIT_CNT;
  logic            BUSY;
  logic            CRD_ERR;
`ifdef SORT_FEEDER_STAT_EN
  logic [31:0]     STAT_CHUNKS;
  logic [31:0]     STAT_PADS;
`endif

  sort_chunk_feeder #(.P_LOG(P_LOG), .DATW(DATW), .KEYW(32), .CREDITS(CREDITS)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST),
    .DIN_READY(DIN_READY), .NET_DIN(NET_DIN), .NET_DINEN(NET_DINEN),
    .CHUNK_LAST(CHUNK_LAST), .CRD_RET(CRD_RET), .CREDIT_CNT(CREDIT_CNT),
    .BUSY(BUSY), .CRD_ERR(CRD_ERR)
`ifdef SORT_FEEDER_STAT_EN
    , .STAT_CHUNKS(STAT_CHUNKS), .STAT_PADS(STAT_PADS)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: records collect in a queue; a completed chunk waits until its
  // ready cycle and a credit, then leaves as one pulse.
  logic [DATW-1:0] cur[$];
  bit              have;
  logic [W-1:0]    m_chunk;
  bit              m_last;
  int              ready_at;
  int              m_cred;
  bit              m_err;
  int              m_padn;
  logic [31:0]     m_chunks;
  logic [31:0]     m_pads;

  task automatic model_reset();
    cur.delete();
    have = 0;
    m_cred = CREDITS;
    m_err = 0;
    m_padn = 0;
    m_chunks = '0;
    m_pads = '0;
  endtask

  task automatic form_chunk(input bit last);
    m_chunk = '0;
    for (int i = 0; i < N; i++)
      m_chunk[i*DATW +: DATW] = (i < cur.size()) ? cur[i] : PAD_REC;
    m_padn = N - cur.size();
    m_last = last;
    ready_at = cyc + ((cur.size() == N) ? 1 : 2);
    have = 1;
    cur.delete();
  endtask

  task automatic cycle();
    bit rdy;
    bit pulse;
    @(negedge CLK);
    rdy = !have;
    pulse = have && (cyc >= ready_at) && (m_cred > 0);
    if (!RST) begin
      check("din_ready", W'(DIN_READY), W'(rdy));
      check("net_dinen", W'(NET_DINEN), W'(pulse));
      check("credit_cnt", W'(CREDIT_CNT), W'(m_cred));
      check("busy", W'(BUSY), W'(have || cur.size() != 0));
      check("crd_err", W'(CRD_ERR), W'(m_err));
      if (pulse) begin
        check("net_din", NET_DIN, m_chunk);
        check("chunk_last", W'(CHUNK_LAST), W'(m_last));
      end
`ifdef SORT_FEEDER_STAT_EN
      check("stat_chunks", W'(STAT_CHUNKS), W'(m_chunks));
      check("stat_pads", W'(STAT_PADS), W'(m_pads));
`endif
    end
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      if (pulse) begin
        have = 0;
        m_cred--;
        m_chunks = m_chunks + 32'd1;
        m_pads = m_pads + 32'(m_padn);
      end
      if (CRD_RET) begin
        if (m_cred == CREDITS) m_err = 1;
        else m_cred++;
      end
      if (DIN_VALID && rdy) begin
        cur.push_back(DIN);
        if (cur.size() == N || DIN_LAST) form_chunk(DIN_LAST);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic send_rec(input logic [31:0] key, input bit last);
    bit acc;
    bit done = 0;
    DIN = {$urandom(), key};
    DIN_LAST = last;
    DIN_VALID = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      acc = !have;
      cycle();
      done = acc;
    end
    DIN_VALID = 1'b0;
    DIN_LAST = 1'b0;
    check("send_timeout", W'(done), W'(1));
  endtask

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    CRD_RET = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    DIN_VALID = 1'b0;
    CRD_RET = 1'b0;
    cycle();
    RST = 1'b0;
    check("rst_net_din", NET_DIN, '0);
    check("rst_credit", W'(CREDIT_CNT), W'(CREDITS));
    check("rst_err", W'(CRD_ERR), '0);
    check("rst_ready", W'(DIN_READY), W'(1));
  endtask

  task automatic pulse_ret();
    CRD_RET = 1'b1;
    cycle();
    CRD_RET = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) cycle();
    do_reset();

    // Full chunk, descending keys, no DIN_LAST
    for (int i = 0; i < N; i++) send_rec(32'(15 - i), 1'b0);
    idle(2);
    check("t1_credit", W'(CREDIT_CNT), W'(3));

    // Short set: five records, last on the fifth, padded to N lanes
    for (int i = 0; i < 5; i++) send_rec($urandom(), i == 4);
    idle(3);
`ifdef SORT_FEEDER_STAT_EN
    check("t2_stat_pads", W'(STAT_PADS), W'(11));
`endif

    // Five full chunks with no returns: the fifth waits for a credit
    do_reset();
    for (int i = 0; i < 5 * N; i++) send_rec($urandom(), 1'b0);
    idle(3);
    check("t3_ready", W'(DIN_READY), W'(0));
    check("t3_credit", W'(CREDIT_CNT), W'(0));
    check("t3_busy", W'(BUSY), W'(1));
    pulse_ret();
    idle(1);
    check("t3_credit_after", W'(CREDIT_CNT), W'(0));

    // Return coincident with an issue at count 1
    pulse_ret();
    for (int i = 0; i < N; i++) send_rec($urandom(), i == N - 1);
    pulse_ret();
    check("t4_credit", W'(CREDIT_CNT), W'(1));
    check("t4_err", W'(CRD_ERR), W'(0));

    // Excess return at full count sets the sticky error
    repeat (3) pulse_ret();
    pulse_ret();
    idle(3);
    check("t5_credit", W'(CREDIT_CNT), W'(CREDITS));
    check("t5_err", W'(CRD_ERR), W'(1));
    do_reset();

    // Reset mid-chunk discards the partial chunk
    for (int i = 0; i < 7; i++) send_rec(32'hDEAD_0000 + 32'(i), 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) send_rec(32'h1000 + 32'(i), 1'b0);
    idle(2);
    check("t6_credit", W'(CREDIT_CNT), W'(3));

    // Random traffic; returns only when the downstream holds a chunk
    for (int c = 0; c < 3000; c++) begin
      DIN = {$urandom(), $urandom()};
      DIN_VALID = ($urandom_range(3) != 0);
      DIN_LAST = ($urandom_range(7) == 0);
      CRD_RET = (m_cred < CREDITS) && ($urandom_range(2) == 0);
      cycle();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
